uart_tx_arbiter: RTL

Shares the single UART byte transmitter between four byte-stream requesters. These are, for example, per-video-channel status reporters. Requesters are served round-robin. A requester keeps the grant for a multi-byte message until it sends a byte flagged last. Each accepted byte is presented to the transmitter with a one-cycle start flag and held stable. The next byte is not issued until a full frame time has elapsed, because the transmitter has no busy output.

---
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bus of the UART transmit arbiter.
// Handshake: a requester holds req_valid/req_data/req_last stable until it sees its one-cycle
// req_ready bit; the byte is taken on that clock edge. tx_flag is a one-cycle start pulse
// and tx_data stays stable until the next start pulse.
interface uart_tx_arbiter_if;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_flag;

    modport master (
        output req_data, req_valid, req_last,
        input  req_ready, tx_data, tx_flag
    );

    modport slave (
        input  req_data, req_valid, req_last,
        output req_ready, tx_data, tx_flag
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between four requesters; a grant is
// held for a whole message and byte issues are spaced by one frame time.
module uart_tx_arbiter #(
    parameter int CLK_FEQ  = 50_000_000,
    parameter int UART_BOT = 9600,
    parameter int GAP_BITS = 11
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus,
    output logic [1:0]          grant_ch,
    output logic                busy,
    output logic [1:0]          dbg_state_o,
    output logic [1:0]          dbg_rr_ptr_o
);

    localparam int FRAME_CYC = GAP_BITS * (CLK_FEQ / UART_BOT);
    localparam int CNT_W     = $clog2(FRAME_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_flag_q, tx_flag_d;

    logic             pick_vld;
    logic [1:0]       pick_ch;
    logic [3:0]       ready_w;
    logic [7:0]       sel_byte;

    // Scan from the highest offset down so the channel closest to rr_q wins.
    always_comb begin
        logic [1:0] idx;
        idx      = 2'd0;
        pick_vld = 1'b0;
        pick_ch  = rr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_q + 2'(i);
            if (bus.req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_ch  = idx;
            end
        end
    end

    assign sel_byte = bus.req_data[{grant_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_flag_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_ch;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (bus.req_valid[grant_q]) begin
                    tx_data_d = sel_byte;
                    tx_flag_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                    lock_d    = ~bus.req_last[grant_q];
                    state_d   = WAIT;
                end else begin
                    // Requester dropped valid before the capture edge: abandon the grant.
                    lock_d  = 1'b0;
                    rr_d    = grant_q + 2'd1;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (lock_q) begin
                        state_d = HOLD;
                    end else begin
                        rr_d    = grant_q + 2'd1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (bus.req_valid[grant_q]) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 2'd0;
            rr_q      <= 2'd0;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            tx_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_flag_q <= tx_flag_d;
        end
    end

    always_comb begin
        ready_w = 4'b0000;
        if (state_q == LOAD) begin
            ready_w[grant_q] = 1'b1;
        end
    end

    assign bus.req_ready = ready_w;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_flag   = tx_flag_q;
    assign grant_ch      = grant_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state_o   = state_q;
    assign dbg_rr_ptr_o  = rr_q;

endmodule
